// File: rtl/mul_pipe.sv
// -----------------------------------------------------------------------------
// mul_pipe -- pipelined signed fixed-point multiplier with valid/ready handshake
//
// Purpose
//   Multiplies two signed Q(W-F).F operands and returns a Q(W-F).F result.
//   The product is computed exactly (2W bits), optionally rounded half up,
//   arithmetically shifted right by F, then either saturated or wrapped to
//   W bits. A single global stall enable gives back-pressure: when the output
//   holds a beat that downstream does not take, every stage freezes.
//
// Parameters
//   W       operand / result width (two's complement)
//   F       fractional bits, 1 <= F < W
//   STAGES  register stages from input to output, 1..4 (latency = STAGES)
//   ROUND   0: truncate toward minus infinity, 1: round half up
//   SAT     0: wrap to the low W bits, 1: clamp to the W-bit signed range
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   x1/x2 carry a beat this cycle
//   in_ready   out  block accepts a beat this cycle (equals the stall enable)
//   x1, x2     in   signed operands, W bits
//   out_valid  out  y/ovf carry a result
//   out_ready  in   downstream accepts y/ovf this cycle
//   y          out  signed result, W bits
//   ovf        out  result was out of range (clamped or wrapped)
// -----------------------------------------------------------------------------
module mul_pipe #(
    parameter int W      = 16,
    parameter int F      = 8,
    parameter int STAGES = 2,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf
);

    localparam logic signed [2*W:0]  HALF = (2*W+1)'(1) << (F - 1);
    localparam logic        [W-1:0]  YMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic        [W-1:0]  YMIN = {1'b1, {(W-1){1'b0}}};

    // Add the rounding constant (if enabled) and arithmetic-shift by F.
    // One guard bit above the 2W-bit product means the +2^(F-1) can never
    // overflow, even for the (-2^(W-1))^2 corner.
    function automatic logic signed [2*W:0] round_shift(input logic signed [2*W-1:0] p);
        logic signed [2*W:0] e;
        e = {p[2*W-1], p};
        if (ROUND != 0) begin
            e = e + HALF;
        end
        return e >>> F;
    endfunction

    // Reduce the shifted value to W bits. The value fits exactly when bits
    // [2W:W-1] are all copies of the W-bit sign. Returns {ovf, y}.
    function automatic logic [W:0] sat_wrap(input logic signed [2*W:0] s);
        logic         fits;
        logic [W-1:0] r;
        fits = (s[2*W:W-1] == {(W+2){s[W-1]}});
        r    = s[W-1:0];
        if (!fits && (SAT != 0)) begin
            r = s[2*W] ? YMIN : YMAX;
        end
        return {!fits, r};
    endfunction

    // Global stall: everything advances unless a result is stuck at the output.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Exact full-width product of the sign-extended operands.
    logic signed [2*W-1:0] x1_ext;
    logic signed [2*W-1:0] x2_ext;
    logic signed [2*W-1:0] prod_c;

    assign x1_ext = {{W{x1[W-1]}}, x1};
    assign x2_ext = {{W{x2[W-1]}}, x2};
    assign prod_c = x1_ext * x2_ext;

    logic signed [2*W-1:0] prod_fin;
    logic                  vld_fin;

    generate
        if (STAGES == 1) begin : g_nodly
            // Single stage: product feeds the output stage directly.
            assign prod_fin = prod_c;
            assign vld_fin  = in_valid;
        end else begin : g_dly
            logic signed [2*W-1:0] prod_p [STAGES-1];
            logic                  vld_p  [STAGES-1];

            // ---- stage 1: register the full product; later entries are pure delay ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES - 1; i++) begin
                        prod_p[i] <= '0;
                        vld_p[i]  <= 1'b0;
                    end
                end else if (en) begin
                    // en=1 implies in_ready=1, so in_valid alone marks an accept.
                    prod_p[0] <= prod_c;
                    vld_p[0]  <= in_valid;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        prod_p[i] <= prod_p[i-1];
                        vld_p[i]  <= vld_p[i-1];
                    end
                end
            end

            assign prod_fin = prod_p[STAGES-2];
            assign vld_fin  = vld_p[STAGES-2];
        end
    endgenerate

    logic [W:0] res_c;
    assign res_c = sat_wrap(round_shift(prod_fin));

    // ---- final stage: round, shift, saturate/wrap, register outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= vld_fin;
            y         <= res_c[W-1:0];
            ovf       <= res_c[W];
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
module tb_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] x1 = '0;
    logic [15:0] x2 = '0;

    logic        m_in_ready, m_out_valid, m_ovf;
    logic [15:0] m_y;
    logic        t_in_ready, t_out_valid, t_ovf;
    logic [15:0] t_y;
    logic        w_in_ready, w_out_valid, w_ovf;
    logic [15:0] w_y;
    logic        s1_in_ready, s1_out_valid, s1_ovf;
    logic [15:0] s1_y;
    logic        s4_in_ready, s4_out_valid, s4_ovf;
    logic [15:0] s4_y;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_pipe #(.W(16), .F(8), .STAGES(2), .ROUND(1), .SAT(1)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .x1(x1), .x2(x2), .out_valid(m_out_valid), .out_ready(out_ready),
        .y(m_y), .ovf(m_ovf));

    mul_pipe #(.W(16), .F(8), .STAGES(2), .ROUND(0), .SAT(1)) u_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .x1(x1), .x2(x2), .out_valid(t_out_valid), .out_ready(out_ready),
        .y(t_y), .ovf(t_ovf));

    mul_pipe #(.W(16), .F(8), .STAGES(2), .ROUND(1), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .x1(x1), .x2(x2), .out_valid(w_out_valid), .out_ready(out_ready),
        .y(w_y), .ovf(w_ovf));

    mul_pipe #(.W(16), .F(8), .STAGES(1), .ROUND(1), .SAT(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready),
        .x1(x1), .x2(x2), .out_valid(s1_out_valid), .out_ready(out_ready),
        .y(s1_y), .ovf(s1_ovf));

    mul_pipe #(.W(16), .F(8), .STAGES(4), .ROUND(1), .SAT(1)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s4_in_ready),
        .x1(x1), .x2(x2), .out_valid(s4_out_valid), .out_ready(out_ready),
        .y(s4_y), .ovf(s4_ovf));

    typedef struct {
        logic [15:0] x1;
        logic [15:0] x2;
        logic [15:0] y_rs;  logic o_rs;   // ROUND=1 SAT=1
        logic [15:0] y_ts;  logic o_ts;   // ROUND=0 SAT=1
        logic [15:0] y_rw;  logic o_rw;   // ROUND=1 SAT=0
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        int          cyc;
    } sb_t;

    vec_t tv[13];
    sb_t  q1[$];
    sb_t  q4[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: 64-bit integer arithmetic, Q8.8.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input int rnd, input int sat);
        longint      p;
        longint      s;
        logic [15:0] r;
        logic        o;
        p = longint'($signed(a)) * longint'($signed(b));
        if (rnd != 0) p = p + 128;
        s = p >>> 8;
        o = (s > 32767) || (s < -32768);
        r = s[15:0];
        if (o && (sat != 0)) r = (s > 0) ? 16'h7FFF : 16'h8000;
        return {o, r};
    endfunction

    function automatic logic [15:0] pick_op();
        logic [15:0] corners[7];
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0100, 16'hFF00};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 6)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [16:0] got[$];
        logic [16:0] ev;
        logic [15:0] prev_y;
        logic        prev_o;
        bit          prev_stall;
        int          sent;
        sb_t         e;

        tv[0]  = '{16'h0180, 16'hFE00, 16'hFD00, 1'b0, 16'hFD00, 1'b0, 16'hFD00, 1'b0};
        tv[1]  = '{16'h6400, 16'h0200, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'hC800, 1'b1};
        tv[2]  = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'h0000, 1'b1};
        tv[3]  = '{16'h0001, 16'h0080, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0};
        tv[4]  = '{16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        tv[5]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'hFF00, 1'b1};
        tv[6]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 16'h8000, 1'b0, 16'h8000, 1'b0};
        tv[7]  = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
        tv[8]  = '{16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tv[9]  = '{16'h0280, 16'h0180, 16'h03C0, 1'b0, 16'h03C0, 1'b0, 16'h03C0, 1'b0};
        tv[10] = '{16'hFFFF, 16'h0180, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0, 16'hFFFF, 1'b0};
        tv[11] = '{16'h0001, 16'h0180, 16'h0002, 1'b0, 16'h0001, 1'b0, 16'h0002, 1'b0};
        tv[12] = '{16'h9C00, 16'h0200, 16'h8000, 1'b1, 16'h8000, 1'b1, 16'h3800, 1'b1};

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("reset main {v,o,y}", {14'b0, m_out_valid, m_ovf, m_y}, 32'h0);
        check("reset s4 {v,o,y}", {14'b0, s4_out_valid, s4_ovf, s4_y}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", {31'b0, m_in_ready}, 32'h1);

        // Directed table: one beat at a time, latency checked per instance
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            x1 = tv[i].x1; x2 = tv[i].x2; in_valid = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk); #1;
                if (k == 1) begin
                    in_valid = 1'b0;
                    check($sformatf("v%0d s1", i), {14'b0, s1_out_valid, s1_ovf, s1_y},
                          {14'b0, 1'b1, tv[i].o_rs, tv[i].y_rs});
                    check($sformatf("v%0d main early", i), {31'b0, m_out_valid}, 32'h0);
                end else if (k == 2) begin
                    check($sformatf("v%0d main", i), {14'b0, m_out_valid, m_ovf, m_y},
                          {14'b0, 1'b1, tv[i].o_rs, tv[i].y_rs});
                    check($sformatf("v%0d trunc", i), {14'b0, t_out_valid, t_ovf, t_y},
                          {14'b0, 1'b1, tv[i].o_ts, tv[i].y_ts});
                    check($sformatf("v%0d wrap", i), {14'b0, w_out_valid, w_ovf, w_y},
                          {14'b0, 1'b1, tv[i].o_rw, tv[i].y_rw});
                    check($sformatf("v%0d s1 single", i), {31'b0, s1_out_valid}, 32'h0);
                end else if (k == 3) begin
                    check($sformatf("v%0d main single", i), {31'b0, m_out_valid}, 32'h0);
                    check($sformatf("v%0d s4 early", i), {31'b0, s4_out_valid}, 32'h0);
                end else begin
                    check($sformatf("v%0d s4", i), {14'b0, s4_out_valid, s4_ovf, s4_y},
                          {14'b0, 1'b1, tv[i].o_rs, tv[i].y_rs});
                end
            end
        end

        // Streaming random operands into STAGES=1 and STAGES=4, full throughput
        @(posedge clk); #1;
        for (int c = 0; c < 70; c++) begin
            if (s1_out_valid) begin
                if (q1.size() == 0) check("s1 extra beat", 32'h1, 32'h0);
                else begin
                    e = q1.pop_front();
                    check("s1 rand {o,y}", {15'b0, s1_ovf, s1_y}, {15'b0, e.exp});
                    check("s1 rand latency", 32'(c - e.cyc), 32'd1);
                end
            end
            if (s4_out_valid) begin
                if (q4.size() == 0) check("s4 extra beat", 32'h1, 32'h0);
                else begin
                    e = q4.pop_front();
                    check("s4 rand {o,y}", {15'b0, s4_ovf, s4_y}, {15'b0, e.exp});
                    check("s4 rand latency", 32'(c - e.cyc), 32'd4);
                end
            end
            if (c < 60) begin
                x1 = pick_op(); x2 = pick_op(); in_valid = 1'b1;
                e.exp = model(x1, x2, 1, 1);
                e.cyc = c;
                q1.push_back(e);
                q4.push_back(e);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("s1 queue drained", 32'(q1.size()), 32'h0);
        check("s4 queue drained", 32'(q4.size()), 32'h0);

        // Back-pressure: 8 beats, out_ready low for cycles 3..6
        sent = 0;
        prev_stall = 1'b0;
        prev_y = '0;
        prev_o = 1'b0;
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 8) begin
                x1 = 16'((sent + 1) * 256); x2 = 16'hFF80; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall)
                check("bp hold {v,o,y}", {14'b0, m_out_valid, m_ovf, m_y},
                      {14'b0, 1'b1, prev_o, prev_y});
            check("bp in_ready", {31'b0, m_in_ready}, {31'b0, !(m_out_valid && !out_ready)});
            if (in_valid && m_in_ready) sent++;
            if (m_out_valid && out_ready) got.push_back({m_ovf, m_y});
            prev_stall = m_out_valid && !out_ready;
            prev_y = m_y;
            prev_o = m_ovf;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp beat count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            ev = model(16'((i + 1) * 256), 16'hFF80, 1, 1);
            check($sformatf("bp beat %0d", i), {15'b0, got[i]}, {15'b0, ev});
        end

        // Reset with beats in flight
        repeat (6) @(negedge clk);
        x1 = 16'h0180; x2 = 16'hFE00; in_valid = 1'b1;
        @(negedge clk);
        x1 = 16'h0280; x2 = 16'h0180;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre-rst main {v,o,y}", {14'b0, m_out_valid, m_ovf, m_y}, {14'b0, 1'b1, 1'b0, 16'hFD00});
        #2 rst = 1'b1;
        #1;
        check("async rst main {v,o,y}", {14'b0, m_out_valid, m_ovf, m_y}, 32'h0);
        check("async rst s4 valid", {31'b0, s4_out_valid}, 32'h0);
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post-rst main valid", {31'b0, m_out_valid}, 32'h0);
            check("post-rst s4 valid", {31'b0, s4_out_valid}, 32'h0);
        end
        check("post-rst in_ready", {31'b0, m_in_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
